// File: rtl/nrzi_stuff_encoder_if.sv
// nrzi_stuff_encoder_if: serializer-side handshake and line outputs of the NRZI bit-stuffing encoder.
interface nrzi_stuff_encoder_if;
  logic en;
  logic pulse;
  logic data_bit;
  logic data_valid;
  logic data_ready;
  logic encoded_bit;
  logic stuffing;
  logic underrun;
  modport master (
    output en, pulse, data_bit, data_valid,
    input  data_ready, encoded_bit, stuffing, underrun
  );
  modport slave (
    input  en, pulse, data_bit, data_valid,
    output data_ready, encoded_bit, stuffing, underrun
  );
endinterface

// File: rtl/nrzi_stuff_encoder.sv
// nrzi_stuff_encoder: USB bit stuffing (forced 0 after STUFF_LEN ones) followed by NRZI line encoding.
module nrzi_stuff_encoder #(
  parameter int STUFF_LEN = 6
) (
  input  logic                 clk,
  input  logic                 nRST,
  nrzi_stuff_encoder_if.slave  bus
);
  localparam int CW = $clog2(STUFF_LEN + 1);
  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n, w_inc;
  logic          r_enc, w_enc_n;
  logic          r_stuff, w_stuff_n;
  logic          r_under, w_under_n;
  assign w_inc           = r_cnt + CW'(1);
  assign bus.data_ready  = bus.en & bus.pulse & (r_state == SEND);
  assign bus.encoded_bit = r_enc;
  assign bus.stuffing    = r_stuff;
  assign bus.underrun    = r_under;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_enc   <= 1'b1;
      r_stuff <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_enc   <= w_enc_n;
      r_stuff <= w_stuff_n;
      r_under <= w_under_n;
    end
  end
  // Disable wins over everything, including a pending stuff bit.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_enc_n   = r_enc;
    w_stuff_n = r_stuff;
    w_under_n = 1'b0;
    if (!bus.en || r_state == IDLE) begin
      w_state_n = bus.en ? SEND : IDLE;
      w_cnt_n   = '0;
      w_enc_n   = 1'b1;
      w_stuff_n = 1'b0;
    end else if (bus.pulse) begin
      if (r_state == STUFF) begin
        w_state_n = SEND;
        w_cnt_n   = '0;
        w_enc_n   = ~r_enc;
        w_stuff_n = 1'b1;
      end else begin
        w_stuff_n = 1'b0;
        if (!bus.data_valid) begin
          w_under_n = 1'b1;
        end else if (!bus.data_bit) begin
          w_enc_n = ~r_enc;
          w_cnt_n = '0;
        end else begin
          w_cnt_n   = w_inc;
          w_state_n = (w_inc == CW'(STUFF_LEN)) ? STUFF : SEND;
        end
      end
    end
  end
endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// tb_nrzi_stuff_encoder: table-driven pulse vectors with a scoreboard, plus back-to-back and async-reset sequences.
module tb_nrzi_stuff_encoder;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  nrzi_stuff_encoder_if bus ();
  nrzi_stuff_encoder #(.STUFF_LEN(6)) dut (.clk(clk), .nRST(nRST), .bus(bus));
  typedef struct {
    logic en, v, b, rdy, enc, stf, und;
  } vec_t;
  vec_t tbl[$];
  logic [2:0] sb[$];
  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask
  task automatic add(input logic en, v, b, rdy, enc, stf, und, input int n = 1);
    for (int k = 0; k < n; k++) tbl.push_back('{en, v, b, rdy, enc, stf, und});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] e;
    logic line;
    bus.en = 0; bus.pulse = 0; bus.data_bit = 0; bus.data_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enc", bus.encoded_bit, 1'b1);
    chk("rst_stf", bus.stuffing, 1'b0);
    chk("rst_und", bus.underrun, 1'b0);
    @(negedge clk) nRST = 1;
    //  en v  b  rdy enc stf und
    add(0, 1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0, 6);
    add(1, 1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0, 6);
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0, 3);
    add(1, 0, 0, 1, 1, 0, 1);
    add(1, 1, 1, 1, 1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0, 6);
    add(0, 1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.en = tbl[i].en; bus.data_valid = tbl[i].v; bus.data_bit = tbl[i].b; bus.pulse = 1;
      #1;
      chk($sformatf("row%0d_rdy", i), bus.data_ready, tbl[i].rdy);
      sb.push_back({tbl[i].enc, tbl[i].stf, tbl[i].und});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d_enc", i), bus.encoded_bit, e[2]);
      chk($sformatf("row%0d_stf", i), bus.stuffing, e[1]);
      chk($sformatf("row%0d_und", i), bus.underrun, e[0]);
      @(negedge clk) bus.pulse = 0;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_gap_enc", i), bus.encoded_bit, e[2]);
      chk($sformatf("row%0d_gap_und", i), bus.underrun, 1'b0);
    end
    @(negedge clk);
    bus.en = 1; bus.pulse = 1; bus.data_valid = 1; bus.data_bit = 0;
    #1 chk("b2b_idle_rdy", bus.data_ready, 1'b0);
    @(posedge clk);
    #1 chk("b2b_start_enc", bus.encoded_bit, 1'b1);
    line = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b%0d_rdy", k), bus.data_ready, 1'b1);
      line = ~line;
      sb.push_back({line, 2'b00});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("b2b%0d_enc", k), bus.encoded_bit, e[2]);
      chk($sformatf("b2b%0d_und", k), bus.underrun, e[0]);
    end
    bus.data_valid = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_enc", bus.encoded_bit, 1'b0);
    chk("pre_rst_und", bus.underrun, 1'b1);
    #2 nRST = 0;
    #1;
    chk("async_rst_enc", bus.encoded_bit, 1'b1);
    chk("async_rst_stf", bus.stuffing, 1'b0);
    chk("async_rst_und", bus.underrun, 1'b0);
    bus.en = 0; bus.pulse = 0;
    #1 chk("rst_rdy", bus.data_ready, 1'b0);
    @(negedge clk) nRST = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
